// File: rtl/mem_write_checker.sv
// Watches processor stores for one decisive write (pass/fail/timeout verdict) and logs stores seen in RUN.
// Verdict and log update register on the store edge; a full log drops stores unless a pop frees a slot that edge.
module mem_write_checker #(
  parameter logic [31:0] EXP_ADDR    = 32'd84,
  parameter logic [31:0] EXP_DATA    = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  parameter int          LIMIT       = 42,
  parameter int          DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  input  logic                       clear,
  input  logic                       log_pop,
  output logic                       log_valid,
  output logic [31:0]                log_addr,
  output logic [31:0]                log_data,
  output logic [$clog2(DEPTH):0]     log_count,
  output logic                       overflow,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [7:0]                 cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cycles_q, cycles_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            done_q, pass_q, fail_q, timeout_q;

  logic [31:0]     addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic            store, push, full, empty, pop_en, push_en;

  assign store  = (state_q == S_RUN) && memwrite;
  assign push   = store && !clear;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop_en = log_pop && !empty && !clear;
  // A pop on a full log frees the slot the simultaneous push lands in.
  assign push_en = push && (!full || pop_en);

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    if (clear) begin
      state_d  = S_RUN;
      cycles_d = '0;
    end else if (state_q == S_RUN) begin
      if (store && dataadr == EXP_ADDR) begin
        state_d = (writedata == EXP_DATA) ? S_PASS : S_FAIL;
      end else if (store && dataadr != IGNORE_ADDR) begin
        state_d = S_FAIL;
      end else if (int'(cycles_q) == LIMIT) begin
        state_d = S_TIMEOUT;
      end else if (cycles_q != 8'hFF) begin
        cycles_d = cycles_q + 8'd1;
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push_en) wptr_d = wptr_q + AW'(1);
      if (pop_en)  rptr_d = rptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && !push_en) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      cycles_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= (state_d != S_RUN);
      pass_q    <= (state_d == S_PASS);
      fail_q    <= (state_d == S_FAIL);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  // Log storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_mem[wptr_q] <= dataadr;
      data_mem[wptr_q] <= writedata;
    end
  end

  assign log_valid = !empty;
  assign log_addr  = addr_mem[rptr_q];
  assign log_data  = data_mem[rptr_q];
  assign log_count = count_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: vector table plus hand sequences for timeout, overflow and reset.
module tb_mem_write_checker;

  localparam int ST_RUN = 0, ST_PASS = 1, ST_FAIL = 2, ST_TO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, clear, log_pop;
  logic [31:0] dataadr, writedata;
  logic        log_valid, overflow, done, pass, fail, timeout;
  logic [31:0] log_addr, log_data;
  logic [3:0]  log_count;
  logic [7:0]  cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .clear(clear), .log_pop(log_pop),
    .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_count(log_count), .overflow(overflow), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .cycles(cycles)
  );

  typedef struct {
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    logic        clr;
    logic        pop;
    int          st;
    int          cyc;
    int          cnt;
    logic [31:0] ha;
    logic [31:0] hd;
  } vec_t;

  function automatic vec_t mk(input logic mw, input logic [31:0] a, input logic [31:0] d,
                              input logic clr, input logic pop, input int st, input int cyc,
                              input int cnt, input logic [31:0] ha, input logic [31:0] hd);
    vec_t v;
    v.mw = mw; v.a = a; v.d = d; v.clr = clr; v.pop = pop;
    v.st = st; v.cyc = cyc; v.cnt = cnt; v.ha = ha; v.hd = hd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int st, input int cyc, input int cnt, input logic ovf);
    logic [3:0] exp_flags;
    exp_flags = {st != ST_RUN, st == ST_PASS, st == ST_FAIL, st == ST_TO};
    chk({tag, ".flags"}, {28'b0, done, pass, fail, timeout}, {28'b0, exp_flags});
    chk({tag, ".cycles"}, {24'b0, cycles}, cyc);
    chk({tag, ".count"}, {28'b0, log_count}, cnt);
    chk({tag, ".valid"}, {31'b0, log_valid}, {31'b0, cnt != 0});
    chk({tag, ".overflow"}, {31'b0, overflow}, {31'b0, ovf});
  endtask

  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic clr, input logic pop);
    memwrite = mw; dataadr = a; writedata = d; clear = clr; log_pop = pop;
    @(posedge clk);
    #1;
    memwrite = 1'b0; clear = 1'b0; log_pop = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk(1, 80, 3, 0, 0, ST_RUN,  1, 1, 80, 3);
    vecs[1]  = mk(0,  0, 0, 0, 0, ST_RUN,  2, 1, 80, 3);
    vecs[2]  = mk(0,  0, 0, 0, 0, ST_RUN,  3, 1, 80, 3);
    vecs[3]  = mk(0,  0, 0, 0, 0, ST_RUN,  4, 1, 80, 3);
    vecs[4]  = mk(1, 84, 7, 0, 0, ST_PASS, 4, 2, 80, 3);
    vecs[5]  = mk(0,  0, 0, 0, 1, ST_PASS, 4, 1, 84, 7);
    vecs[6]  = mk(1, 88, 1, 1, 0, ST_RUN,  0, 0,  0, 0);
    vecs[7]  = mk(1, 84, 9, 0, 0, ST_FAIL, 0, 1, 84, 9);
    vecs[8]  = mk(1, 84, 7, 0, 0, ST_FAIL, 0, 1, 84, 9);
    vecs[9]  = mk(0,  0, 0, 0, 1, ST_FAIL, 0, 0,  0, 0);
    vecs[10] = mk(0,  0, 0, 0, 1, ST_FAIL, 0, 0,  0, 0);
    vecs[11] = mk(0,  0, 0, 1, 0, ST_RUN,  0, 0,  0, 0);
    vecs[12] = mk(1, 90, 5, 0, 0, ST_FAIL, 0, 1, 90, 5);
    vecs[13] = mk(0,  0, 0, 1, 1, ST_RUN,  0, 0,  0, 0);
    vecs[14] = mk(1, 80, 1, 0, 1, ST_RUN,  1, 1, 80, 1);

    reset = 1'b0; memwrite = 1'b0; clear = 1'b0; log_pop = 1'b0;
    dataadr = '0; writedata = '0;
    #12;
    chk_state("reset", ST_RUN, 0, 0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].clr, vecs[i].pop);
      chk_state(tag, vecs[i].st, vecs[i].cyc, vecs[i].cnt, 1'b0);
      if (vecs[i].cnt != 0) begin
        chk({tag, ".head_addr"}, log_addr, vecs[i].ha);
        chk({tag, ".head_data"}, log_data, vecs[i].hd);
      end
    end

    // Timeout: 42 edges reach the limit, the 43rd times out and cycles freezes.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 42; i++) step(0, 0, 0, 0, 0);
    chk_state("to_before", ST_RUN, 42, 0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk_state("to_edge", ST_TO, 42, 0, 1'b0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    chk_state("to_hold", ST_TO, 42, 0, 1'b0);

    // Decisive store on the limit edge beats the timeout.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 42; i++) step(0, 0, 0, 0, 0);
    step(1, 84, 7, 0, 0);
    chk_state("store_wins", ST_PASS, 42, 1, 1'b0);

    // Overflow, pop+push on full, drain across pointer wrap, pop on empty.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 80, i, 0, 0);
    chk_state("ovf_fill", ST_RUN, 10, 8, 1'b1);
    chk("ovf_fill.head", log_data, 0);
    step(1, 80, 100, 0, 1);
    chk_state("ovf_pushpop", ST_RUN, 11, 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.data", i), log_data, (i < 7) ? i + 1 : 100);
      chk($sformatf("drain%0d.addr", i), log_addr, 80);
      step(0, 0, 0, 0, 1);
    end
    chk_state("drained", ST_RUN, 19, 0, 1'b1);
    step(0, 0, 0, 0, 1);
    chk_state("pop_empty", ST_RUN, 20, 0, 1'b1);

    // Asynchronous reset mid-run after a pass.
    step(1, 84, 7, 0, 0);
    chk_state("pre_reset", ST_PASS, 20, 1, 1'b1);
    #2 reset = 1'b0;
    #2;
    chk_state("async_reset", ST_RUN, 0, 0, 1'b0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    chk_state("post_reset", ST_RUN, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- EXP_ADDR, 84, data address of the decisive store.
- EXP_DATA, 7, required value of the decisive store.
- IGNORE_ADDR, 80, store address that is always tolerated.
- LIMIT, 42, cycle budget before timeout.
- DEPTH, 8, store-log entries (power of two, >=2).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- memwrite, input, 1, processor store strobe.
- dataadr, input, 32, processor store address.
- writedata, input, 32, processor store data.
- clear, input, 1, synchronous restart of the check.
- log_pop, input, 1, consume the head of the store log.
- log_valid, output, 1, store log not empty.
- log_addr, output, 32, address at the log head.
- log_data, output, 32, data at the log head.
- log_count, output, $clog2(DEPTH)+1, occupancy of the store log.
- overflow, output, 1, sticky flag: a store was dropped because the log was full.
- done, output, 1, the check has reached a terminal state.
- pass, output, 1, terminal state is PASS.
- fail, output, 1, terminal state is FAIL.
- timeout, output, 1, terminal state is TIMEOUT.
- cycles, output, 8, cycles spent in RUN.

Function
REQ-003 The FSM SHALL have four states: RUN, PASS, FAIL and TIMEOUT; it leaves reset in RUN.
REQ-004 In RUN, each rising edge with memwrite=1 SHALL be a store event sampled from dataadr and writedata.
REQ-005 A store with dataadr==EXP_ADDR and writedata==EXP_DATA SHALL move the FSM RUN->PASS.
REQ-006 A store with dataadr==EXP_ADDR and writedata!=EXP_DATA SHALL move the FSM RUN->FAIL.
REQ-007 A store to any address other than EXP_ADDR or IGNORE_ADDR SHALL move the FSM RUN->FAIL.
REQ-008 A store to IGNORE_ADDR SHALL leave the FSM in RUN.
REQ-009 cycles SHALL increment by 1 on every edge spent in RUN and SHALL saturate at 255.
REQ-010 If cycles==LIMIT on an edge with no decisive store (REQ-005 to REQ-007), the FSM SHALL move RUN->TIMEOUT; if a decisive store occurs on that same edge, the store SHALL win.
REQ-011 PASS, FAIL and TIMEOUT SHALL be absorbing, leaving only by clear or reset; cycles freezes while the FSM is in a terminal state.
REQ-012 done, pass, fail and timeout SHALL be registered decodes of the state: done=1 in any terminal state, and exactly one of pass, fail or timeout is 1 when done=1.
REQ-013 Every store event in RUN, including the decisive one and stores to IGNORE_ADDR, SHALL be pushed into the store log as an {address, data} pair. Stores made while in a terminal state are not logged.
REQ-014 The log SHALL be a circular FIFO of depth DEPTH; read and write pointers wrap modulo DEPTH.
- log_addr and log_data show the head entry whenever log_valid=1.
- log_valid is equivalent to log_count!=0.
REQ-015 Full log, push only: the entry SHALL be dropped and overflow set to 1; overflow stays set until clear or reset.
REQ-016 Full log, push and log_pop on the same edge: both SHALL occur, log_count is unchanged, and overflow is not set.
REQ-017 log_pop while the log is empty SHALL be ignored, with no pointer movement.
REQ-018 Empty log, push and log_pop on the same edge: the pop SHALL be ignored and the push accepted, giving log_count=1.
REQ-019 clear=1 SHALL, on that edge, return the FSM to RUN and zero cycles, the log pointers, log_count and overflow. A store presented on the same edge SHALL be discarded. clear has priority over every other event.

Reset
REQ-020 When reset is low, the block SHALL immediately return to RUN with cycles=0, an empty log, and overflow, done, pass, fail and timeout all 0, regardless of clk.
REQ-021 Reset asserted mid-operation SHALL discard all log contents and any pending terminal state; operation SHALL resume in RUN on the first rising edge after reset deasserts.
REQ-022 Log storage contents need not be reset; only the pointers and flags are reset.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
- Store m[80]=3, then m[84]=7 on cycle 5 -> pass=1 from cycle 6; log_count=2; log entries in order (80,3),(84,7); overflow=0.
- Store m[84]=9 -> fail=1 on the next edge; a later m[84]=7 -> pass stays 0 and log_count stays 1.
- No stores for 50 cycles -> timeout=1 after exactly 43 edges in RUN; cycles holds 42.
- m[84]=7 presented on the edge where cycles==42 -> pass=1 and timeout=0.
- Ten stores to address 80 with no pops -> log_count=8 and overflow=1. Then pop together with a store -> log_count=8. Then pop eight times -> log_valid=0; a further pop leaves log_count=0.
- After pass, assert clear with a store m[88]=1 on the same edge -> RUN, cycles=0, log empty, fail=0. Pulse reset low mid-run -> all outputs 0 immediately.
